carrier_sweep_ctrl: RTL and testbench

CARRIER_SWEEP_CTRL -- requirements
Module: carrier_sweep_ctrl

---
 rtl/carrier_sweep_ctrl.sv | 166 ++++++++++++++++
 tb/tb_carrier_sweep_ctrl.sv | 175 +++++++++++++++++
 2 files changed

// File: rtl/carrier_sweep_ctrl.sv
// Stepped-frequency carrier sweep controller: walks the FM adapter's phase
// increment through a linear list of points, holding each for a programmed dwell.
module carrier_sweep_ctrl #(
  parameter int PINC_WIDTH  = 32,
  parameter int DWELL_WIDTH = 24,
  parameter int STEPS_WIDTH = 16
) (
  input  logic                   aclk,
  input  logic                   areset,
  input  logic                   start,
  input  logic                   abort,
  input  logic                   cfg_loop,
  input  logic [PINC_WIDTH-1:0]  cfg_pinc_start,
  input  logic [PINC_WIDTH-1:0]  cfg_pinc_step,
  input  logic [STEPS_WIDTH-1:0] cfg_num_steps,
  input  logic [DWELL_WIDTH-1:0] cfg_dwell,
  input  logic                   fm_request,
  output logic [PINC_WIDTH-1:0]  phase_carrier,
  output logic                   fm_enable,
  output logic                   busy,
  output logic                   step_strobe,
  output logic [STEPS_WIDTH-1:0] step_index,
  output logic                   done,
  output logic                   aborted
);

  typedef enum logic [1:0] {IDLE, DWELL, ADVANCE} state_t;

  state_t                 state_q, state_d;
  logic [PINC_WIDTH-1:0]  phase_q, phase_d;
  logic [PINC_WIDTH-1:0]  pinc_start_q, pinc_start_d;
  logic [PINC_WIDTH-1:0]  pinc_step_q, pinc_step_d;
  logic [STEPS_WIDTH-1:0] idx_q, idx_d;
  logic [STEPS_WIDTH-1:0] last_q, last_d;
  logic [DWELL_WIDTH-1:0] dwell_rl_q, dwell_rl_d;
  logic [DWELL_WIDTH-1:0] cnt_q, cnt_d;
  logic                   loop_q, loop_d;
  logic                   busy_q, busy_d;
  logic                   strobe_q, strobe_d;
  logic                   done_q, done_d;
  logic                   aborted_q, aborted_d;
  logic                   fm_q, fm_d;

  always_comb begin
    state_d      = state_q;
    phase_d      = phase_q;
    pinc_start_d = pinc_start_q;
    pinc_step_d  = pinc_step_q;
    idx_d        = idx_q;
    last_d       = last_q;
    dwell_rl_d   = dwell_rl_q;
    cnt_d        = cnt_q;
    loop_d       = loop_q;
    busy_d       = busy_q;
    strobe_d     = 1'b0;
    done_d       = 1'b0;
    aborted_d    = 1'b0;

    case (state_q)
      IDLE: begin
        // abort alongside start cancels the request outright
        if (start && !abort) begin
          if (cfg_num_steps != '0) begin
            pinc_start_d = cfg_pinc_start;
            pinc_step_d  = cfg_pinc_step;
            last_d       = cfg_num_steps - STEPS_WIDTH'(1);
            // counter is loaded with hold-length minus one; dwell of 0 acts as 1
            dwell_rl_d   = (cfg_dwell == '0) ? '0 : cfg_dwell - DWELL_WIDTH'(1);
            cnt_d        = (cfg_dwell == '0) ? '0 : cfg_dwell - DWELL_WIDTH'(1);
            loop_d       = cfg_loop;
            phase_d      = cfg_pinc_start;
            idx_d        = '0;
            busy_d       = 1'b1;
            strobe_d     = 1'b1;
            state_d      = DWELL;
          end else begin
            done_d = 1'b1;
          end
        end
      end
      DWELL: begin
        if (abort) begin
          state_d   = IDLE;
          busy_d    = 1'b0;
          aborted_d = 1'b1;
        end else if (cnt_q == '0) begin
          state_d = ADVANCE;
        end else begin
          cnt_d = cnt_q - DWELL_WIDTH'(1);
        end
      end
      ADVANCE: begin
        if (abort) begin
          state_d   = IDLE;
          busy_d    = 1'b0;
          aborted_d = 1'b1;
        end else if (idx_q != last_q) begin
          phase_d  = phase_q + pinc_step_q;
          idx_d    = idx_q + STEPS_WIDTH'(1);
          cnt_d    = dwell_rl_q;
          strobe_d = 1'b1;
          state_d  = DWELL;
        end else if (loop_q) begin
          phase_d  = pinc_start_q;
          idx_d    = '0;
          cnt_d    = dwell_rl_q;
          strobe_d = 1'b1;
          state_d  = DWELL;
        end else begin
          busy_d  = 1'b0;
          done_d  = 1'b1;
          state_d = IDLE;
        end
      end
      default: begin
        state_d = IDLE;
        busy_d  = 1'b0;
      end
    endcase

    fm_d = busy_d ? 1'b0 : fm_request;
  end

  always_ff @(posedge aclk or posedge areset) begin
    if (areset) begin
      state_q      <= IDLE;
      phase_q      <= '0;
      pinc_start_q <= '0;
      pinc_step_q  <= '0;
      idx_q        <= '0;
      last_q       <= '0;
      dwell_rl_q   <= '0;
      cnt_q        <= '0;
      loop_q       <= 1'b0;
      busy_q       <= 1'b0;
      strobe_q     <= 1'b0;
      done_q       <= 1'b0;
      aborted_q    <= 1'b0;
      fm_q         <= 1'b0;
    end else begin
      state_q      <= state_d;
      phase_q      <= phase_d;
      pinc_start_q <= pinc_start_d;
      pinc_step_q  <= pinc_step_d;
      idx_q        <= idx_d;
      last_q       <= last_d;
      dwell_rl_q   <= dwell_rl_d;
      cnt_q        <= cnt_d;
      loop_q       <= loop_d;
      busy_q       <= busy_d;
      strobe_q     <= strobe_d;
      done_q       <= done_d;
      aborted_q    <= aborted_d;
      fm_q         <= fm_d;
    end
  end

  assign phase_carrier = phase_q;
  assign fm_enable     = fm_q;
  assign busy          = busy_q;
  assign step_strobe   = strobe_q;
  assign step_index    = idx_q;
  assign done          = done_q;
  assign aborted       = aborted_q;

endmodule

// File: tb/tb_carrier_sweep_ctrl.sv
// Directed bench for carrier_sweep_ctrl: hand-computed sequences checked with
// immediate assertions one cycle at a time.
module tb_carrier_sweep_ctrl;

  logic        aclk = 1'b0;
  logic        areset;
  logic        start, abort, cfg_loop, fm_request;
  logic [31:0] cfg_pinc_start, cfg_pinc_step;
  logic [15:0] cfg_num_steps;
  logic [23:0] cfg_dwell;
  logic [31:0] phase_carrier;
  logic        fm_enable, busy, step_strobe, done, aborted;
  logic [15:0] step_index;

  int checks = 0;
  int errors = 0;

  carrier_sweep_ctrl dut (
    .aclk(aclk), .areset(areset), .start(start), .abort(abort),
    .cfg_loop(cfg_loop), .cfg_pinc_start(cfg_pinc_start),
    .cfg_pinc_step(cfg_pinc_step), .cfg_num_steps(cfg_num_steps),
    .cfg_dwell(cfg_dwell), .fm_request(fm_request),
    .phase_carrier(phase_carrier), .fm_enable(fm_enable), .busy(busy),
    .step_strobe(step_strobe), .step_index(step_index), .done(done),
    .aborted(aborted)
  );

  always #5 aclk = ~aclk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // advance one edge and settle before sampling
  task automatic tick();
    @(posedge aclk);
    #1;
  endtask

  task automatic chk_all(input string tag, input logic [31:0] ph, input logic [15:0] idx,
                         input logic b, input logic s, input logic d, input logic a,
                         input logic f);
    chk({tag, ".phase"}, phase_carrier, ph);
    chk({tag, ".idx"}, {16'h0, step_index}, {16'h0, idx});
    chk({tag, ".busy"}, {31'h0, busy}, {31'h0, b});
    chk({tag, ".strobe"}, {31'h0, step_strobe}, {31'h0, s});
    chk({tag, ".done"}, {31'h0, done}, {31'h0, d});
    chk({tag, ".aborted"}, {31'h0, aborted}, {31'h0, a});
    chk({tag, ".fm"}, {31'h0, fm_enable}, {31'h0, f});
  endtask

  logic [31:0] lp_phase [8];
  logic [15:0] lp_idx   [8];
  logic        lp_strb  [8];

  initial begin
    areset = 1'b1; start = 0; abort = 0; cfg_loop = 0; fm_request = 0;
    cfg_pinc_start = 0; cfg_pinc_step = 0; cfg_num_steps = 0; cfg_dwell = 0;
    #12;
    chk_all("reset", 32'h0, 16'h0, 0, 0, 0, 0, 0);
    areset = 1'b0;
    tick();
    chk_all("post_reset", 32'h0, 16'h0, 0, 0, 0, 0, 0);

    // basic 3-point sweep, dwell 4; config changed after capture must not matter
    cfg_pinc_start = 32'h1000; cfg_pinc_step = 32'h100; cfg_num_steps = 3; cfg_dwell = 4;
    start = 1;
    tick();
    start = 0;
    cfg_pinc_step = 32'h999; cfg_num_steps = 7; cfg_dwell = 1; cfg_pinc_start = 32'h7777;
    for (int k = 0; k < 15; k++) begin
      if (k != 0) tick();
      chk_all($sformatf("sweep_k%0d", k), 32'h1000 + 32'h100 * (k / 5), 16'(k / 5),
              1, (k % 5) == 0, 0, 0, 0);
    end
    tick();
    chk_all("sweep_end", 32'h1200, 16'd2, 0, 0, 1, 0, 0);
    tick();
    chk_all("sweep_idle", 32'h1200, 16'd2, 0, 0, 0, 0, 0);

    // wrap-around with dwell 0 (one cycle per point)
    cfg_pinc_start = 32'hFFFF_FF00; cfg_pinc_step = 32'h200; cfg_num_steps = 2; cfg_dwell = 0;
    start = 1;
    tick();
    start = 0;
    chk_all("wrap_d0", 32'hFFFF_FF00, 16'd0, 1, 1, 0, 0, 0);
    tick();
    chk_all("wrap_a0", 32'hFFFF_FF00, 16'd0, 1, 0, 0, 0, 0);
    tick();
    chk_all("wrap_d1", 32'h0000_0100, 16'd1, 1, 1, 0, 0, 0);
    tick();
    chk_all("wrap_a1", 32'h0000_0100, 16'd1, 1, 0, 0, 0, 0);
    tick();
    chk_all("wrap_end", 32'h0000_0100, 16'd1, 0, 0, 1, 0, 0);

    // zero-step request: immediate done, never busy
    cfg_num_steps = 0;
    start = 1;
    tick();
    start = 0;
    chk_all("zero_done", 32'h0000_0100, 16'd1, 0, 0, 1, 0, 0);
    tick();
    chk_all("zero_idle", 32'h0000_0100, 16'd1, 0, 0, 0, 0, 0);

    // looping sweep aborted during the third point
    lp_phase = '{32'h5000, 32'h5000, 32'h5000, 32'h5010, 32'h5010, 32'h5010, 32'h5000, 32'h5000};
    lp_idx   = '{16'd0, 16'd0, 16'd0, 16'd1, 16'd1, 16'd1, 16'd0, 16'd0};
    lp_strb  = '{1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0};
    cfg_pinc_start = 32'h5000; cfg_pinc_step = 32'h10; cfg_num_steps = 2; cfg_dwell = 2;
    cfg_loop = 1;
    start = 1;
    tick();
    start = 0;
    for (int k = 0; k < 8; k++) begin
      if (k != 0) tick();
      chk_all($sformatf("loop_k%0d", k), lp_phase[k], lp_idx[k], 1, lp_strb[k], 0, 0, 0);
    end
    abort = 1;
    tick();
    abort = 0;
    cfg_loop = 0;
    chk_all("loop_abort", 32'h5000, 16'd0, 0, 0, 0, 1, 0);
    tick();
    chk_all("loop_idle", 32'h5000, 16'd0, 0, 0, 0, 0, 0);

    // fm_enable follows request only while idle
    fm_request = 1;
    tick();
    chk_all("fm_idle", 32'h5000, 16'd0, 0, 0, 0, 0, 1);
    cfg_pinc_start = 32'h0abc; cfg_num_steps = 1; cfg_dwell = 1;
    start = 1;
    tick();
    start = 0;
    chk_all("fm_busy_d", 32'h0abc, 16'd0, 1, 1, 0, 0, 0);
    tick();
    chk_all("fm_busy_a", 32'h0abc, 16'd0, 1, 0, 0, 0, 0);
    tick();
    chk_all("fm_end", 32'h0abc, 16'd0, 0, 0, 1, 0, 1);

    // start with abort in idle: nothing happens; abort alone in idle ignored
    cfg_num_steps = 3;
    start = 1; abort = 1;
    tick();
    start = 0;
    chk_all("start_abort", 32'h0abc, 16'd0, 0, 0, 0, 0, 1);
    tick();
    abort = 0;
    chk_all("abort_idle", 32'h0abc, 16'd0, 0, 0, 0, 0, 1);

    // asynchronous reset in the middle of a dwell
    fm_request = 0;
    cfg_pinc_start = 32'h2222; cfg_dwell = 10;
    start = 1;
    tick();
    start = 0;
    tick();
    chk_all("pre_rst", 32'h2222, 16'd0, 1, 0, 0, 0, 0);
    #2 areset = 1;
    #1;
    chk_all("async_rst", 32'h0, 16'd0, 0, 0, 0, 0, 0);
    #1 areset = 0;
    tick();
    chk_all("rst_rel0", 32'h0, 16'd0, 0, 0, 0, 0, 0);
    tick();
    chk_all("rst_rel1", 32'h0, 16'd0, 0, 0, 0, 0, 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
